// File: rtl/di_term_sched.sv
// Terminal-bus scheduler: decodes di_term_addr, latches the terminal per transaction, muxes ready/data/status back, with a ready watchdog.
// Latency: zero in IDLE (combinational decode), ACTIVE one cycle after a mode rises; ready is forced high in TIMEOUT and for unmapped addresses.
// Optional DI_TERM_SCHED_STATS_EN adds timeout_count / last_timeout_term outputs.
module di_term_sched #(
    parameter int          NUM_TERMS      = 4,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] UNMAPPED_DATA  = 16'hDEAD
) (
    input  logic                   ifclk,
    input  logic                   resetb,
    input  logic [15:0]            di_term_addr,
    input  logic                   di_read_mode,
    input  logic                   di_write_mode,
    input  logic [16*NUM_TERMS-1:0] term_addr_tbl,
    input  logic [NUM_TERMS-1:0]   term_read_rdy,
    input  logic [NUM_TERMS-1:0]   term_write_rdy,
    input  logic [16*NUM_TERMS-1:0] term_reg_datao,
    input  logic [16*NUM_TERMS-1:0] term_transfer_status,
    output logic                   di_read_rdy,
    output logic                   di_write_rdy,
    output logic [15:0]            di_reg_datao,
    output logic [15:0]            di_transfer_status,
    output logic [NUM_TERMS-1:0]   term_sel,
    output logic                   busy,
    output logic                   timeout_err
`ifdef DI_TERM_SCHED_STATS_EN
    ,
    output logic [15:0]            timeout_count,
    output logic [3:0]             last_timeout_term
`endif
);

    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [WD_W-1:0] WD_MAX  = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES) : '0;
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, ACTIVE, TIMEOUT} state_t;

    state_t          state_q, state_d;
    logic [3:0]      sel_idx_q;
    logic            unmapped_q;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    logic            any_mode;
    logic            dec_hit;
    logic [3:0]      dec_idx;
    logic [3:0]      cur_idx;
    logic            cur_unm;
    logic            mux_rrdy, mux_wrdy;
    logic [15:0]     mux_data, mux_status;
    logic            wd_rdy;
    logic            wd_fire;

    assign any_mode = di_read_mode | di_write_mode;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = 4'd0;
        for (int i = NUM_TERMS - 1; i >= 0; i--) begin
            if (term_addr_tbl[16*i +: 16] == di_term_addr) begin
                dec_hit = 1'b1;
                dec_idx = 4'(i);
            end
        end
    end

    assign cur_idx = (state_q == IDLE) ? dec_idx  : sel_idx_q;
    assign cur_unm = (state_q == IDLE) ? !dec_hit : unmapped_q;

    always_comb begin
        mux_rrdy   = 1'b0;
        mux_wrdy   = 1'b0;
        mux_data   = 16'h0000;
        mux_status = 16'h0000;
        for (int i = 0; i < NUM_TERMS; i++) begin
            if (cur_idx == 4'(i)) begin
                mux_rrdy   = term_read_rdy[i];
                mux_wrdy   = term_write_rdy[i];
                mux_data   = term_reg_datao[16*i +: 16];
                mux_status = term_transfer_status[16*i +: 16];
            end
        end
    end

    // Read takes precedence when both modes are asserted.
    assign wd_rdy  = di_read_mode ? mux_rrdy : mux_wrdy;
    assign wd_fire = WD_EN && (state_q == ACTIVE) && !unmapped_q && !wd_rdy && (wd_cnt_q == WD_LAST);

    always_comb begin
        wd_cnt_d = '0;
        if (WD_EN && state_q == ACTIVE && any_mode && !unmapped_q && !wd_rdy)
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_mode) state_d = ACTIVE;
            ACTIVE:  if (!any_mode) state_d = IDLE;
                     else if (wd_fire) state_d = TIMEOUT;
            TIMEOUT: if (!any_mode) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        di_read_rdy        = 1'b0;
        di_write_rdy       = 1'b0;
        di_reg_datao       = 16'h0000;
        di_transfer_status = 16'h0000;
        term_sel           = '0;
        busy               = 1'b0;
        if (resetb) begin
            for (int i = 0; i < NUM_TERMS; i++)
                term_sel[i] = !cur_unm && (cur_idx == 4'(i));
            busy = (state_q != IDLE);
            if (state_q == TIMEOUT) begin
                di_read_rdy        = 1'b1;
                di_write_rdy       = 1'b1;
                di_reg_datao       = UNMAPPED_DATA;
                di_transfer_status = mux_status | 16'h8000;
            end else if (cur_unm) begin
                di_read_rdy        = 1'b1;
                di_write_rdy       = 1'b1;
                di_reg_datao       = UNMAPPED_DATA;
                di_transfer_status = 16'h4000;
            end else begin
                di_read_rdy        = mux_rrdy;
                di_write_rdy       = mux_wrdy;
                di_reg_datao       = mux_data;
                di_transfer_status = mux_status;
            end
        end
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            sel_idx_q   <= 4'd0;
            unmapped_q  <= 1'b0;
            wd_cnt_q    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_q == IDLE && any_mode) begin
                sel_idx_q  <= dec_idx;
                unmapped_q <= !dec_hit;
            end
            wd_cnt_q    <= wd_cnt_d;
            timeout_err <= (state_q == ACTIVE) && (state_d == TIMEOUT);
        end
    end

`ifdef DI_TERM_SCHED_STATS_EN
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            timeout_count     <= 16'h0000;
            last_timeout_term <= 4'd0;
        end else if (timeout_err) begin
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'h0001;
            last_timeout_term <= sel_idx_q;
        end
    end
`endif

endmodule

// File: doc/di_term_sched.md
Name: di_term_sched

Overview:
- Controller for the host-interface terminal bus (di_*). Sits between HostInterface and up to NUM_TERMS terminal instances, replacing the ad-hoc combinational term-address mux.
- Decodes di_term_addr and latches the selected terminal for the life of each transaction. Routes ready, data and status back to HostInterface.
- Runs a ready-timeout watchdog so that a terminal that never asserts ready cannot hang the host.

Parameters:
- NUM_TERMS, 4, number of attached terminals (1..16).
- TIMEOUT_CYCLES, 1024, ifclk cycles a selected terminal may hold ready low before timeout; 0 disables the watchdog.
- UNMAPPED_DATA, 16'hDEAD, read data returned for an unmapped term address.

Ports:
- ifclk  in  1  clock (ifclk domain of HostInterface).
- resetb  in  1  asynchronous, active-low reset.
- di_term_addr  in  16  terminal address from HostInterface.
- di_read_mode  in  1  read transaction active.
- di_write_mode  in  1  write transaction active.
- term_addr_tbl  in  16*NUM_TERMS  packed terminal address table (entry i = bits 16i+15:16i).
- term_read_rdy  in  NUM_TERMS  per-terminal read ready.
- term_write_rdy  in  NUM_TERMS  per-terminal write ready.
- term_reg_datao  in  16*NUM_TERMS  packed per-terminal read data.
- term_transfer_status  in  16*NUM_TERMS  packed per-terminal status.
- di_read_rdy  out  1  muxed read ready to HostInterface.
- di_write_rdy  out  1  muxed write ready.
- di_reg_datao  out  16  muxed read data.
- di_transfer_status  out  16  muxed status; bit15 = timeout, bit14 = unmapped.
- term_sel  out  NUM_TERMS  one-hot active terminal (all zero = unmapped/idle).
- busy  out  1  state != IDLE.
- timeout_err  out  1  one-cycle pulse on entering TIMEOUT.

Behaviour:
- Decode: match di_term_addr against term_addr_tbl; lowest matching index wins; no match = unmapped.
- States: IDLE, ACTIVE, TIMEOUT. Reset forces IDLE, sel_q=0, unmapped_q=0, wd_cnt=0, timeout_err=0.
- While resetb is low: di_read_rdy=0, di_write_rdy=0, di_reg_datao=0, di_transfer_status=0, term_sel=0, busy=0.
- IDLE:
  - term_sel and all outputs follow the combinational decode (zero latency).
  - On (di_read_mode | di_write_mode) = 1, latch decode into sel_q/unmapped_q and go to ACTIVE next cycle.
- ACTIVE:
  - Outputs are muxed from sel_q; di_term_addr changes are ignored.
  - Read ready = term_read_rdy[sel]; write ready = term_write_rdy[sel].
  - If both modes are high, read wins for watchdog purposes.
  - When both modes fall, go to IDLE next cycle; wd_cnt clears.
- Unmapped terminal:
  - di_read_rdy=1, di_write_rdy=1 (writes sunk), di_reg_datao=UNMAPPED_DATA.
  - di_transfer_status=16'h4000.
  - The watchdog never fires.
- Watchdog:
  - In ACTIVE with the mode-relevant ready low, wd_cnt increments each cycle; ready high clears wd_cnt to 0.
  - When wd_cnt reaches TIMEOUT_CYCLES-1 with ready still low: next state TIMEOUT, timeout_err pulses for 1 cycle.
  - wd_cnt width is clog2(TIMEOUT_CYCLES+1) and saturates (no wrap).
- TIMEOUT:
  - di_read_rdy=1, di_write_rdy=1, di_reg_datao=UNMAPPED_DATA.
  - di_transfer_status = selected status with bit15 forced to 1.
  - Holds until both modes deassert, then IDLE.
- Mode drop on the same cycle the timeout would fire: go to IDLE, no timeout_err.
- Asynchronous reset mid-transaction: immediate IDLE and all outputs zero; no pulse generated on release.
- di_transfer_status passes terminal bits 13:0 unchanged; bits 15:14 are OR'd with the flags.

Optional Feature:
- Macro: DI_TERM_SCHED_STATS_EN.
- Defined:
  - Adds output timeout_count (16 bit): increments on each timeout_err, saturates at 16'hFFFF, reset 0.
  - Adds output last_timeout_term (4 bit): index of the last timed-out terminal, reset 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Table {0x0001,0x0002,0x0003,0x0004}, addr 0x0002, read_mode high, term1 rdy=1 data 0x1234 -> di_reg_datao=0x1234, di_read_rdy=1, term_sel=4'b0010, busy=1 from the next cycle.
- Read started on addr 0x0003, then addr changed to 0x0001 mid-transaction -> term_sel stays 4'b0100 until mode drops; IDLE one cycle after.
- TIMEOUT_CYCLES=16, term2 read_rdy held 0 -> timeout_err pulses exactly 16 cycles after entering ACTIVE; di_read_rdy=1, di_reg_datao=0xDEAD, status bit15=1 until mode drops.
- Unmapped addr 0x0099 write -> di_write_rdy=1, status=0x4000, no timeout_err after 2000 cycles.
- Assert resetb low in TIMEOUT state -> all outputs 0 immediately; after release, state is IDLE and timeout_err stays 0.
- With DI_TERM_SCHED_STATS_EN defined, 3 timeouts on term 3 -> timeout_count=3, last_timeout_term=3.
